// File: rtl/cart_pkg.sv
// ----------------------------------------------------------------------------
// cart_pkg
// Shared definitions for the cartridge ROM fetch path.
//   IDLE / REQ : fetch FSM state encodings (1-bit, legacy-compatible constants)
//   FILL_BYTE  : value returned to the CPU when a fetch is abandoned
//   sel_byte() : picks the low (a0=0) or high (a0=1) byte of a 16-bit word
// ----------------------------------------------------------------------------
package cart_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // SDRAM words are little-endian: even byte address lives in bits [7:0].
    function automatic logic [7:0] sel_byte(input logic [15:0] word,
                                            input logic        a0);
        return a0 ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/cart_word_buf.sv
// ----------------------------------------------------------------------------
// cart_word_buf
// One-word hit buffer holding the most recently fetched SDRAM word.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   load         : capture load_word/load_tag this cycle
//   load_valid   : validity to record with the loaded word
//   load_tag     : word address of the loaded word
//   load_word    : 16-bit SDRAM word
//   clear        : invalidate the buffer (ignored when load is high)
//   lookup_tag   : word address currently requested by the mapper
//   lookup_a0    : byte-within-word select for the lookup
//   hit          : buffer is valid and tag matches lookup_tag
//   rd_byte      : selected byte of the stored word
// ----------------------------------------------------------------------------
module cart_word_buf
    import cart_pkg::*;
#(
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          load_valid,
    input  logic [TW-1:0] load_tag,
    input  logic [15:0]   load_word,
    input  logic          clear,
    input  logic [TW-1:0] lookup_tag,
    input  logic          lookup_a0,
    output logic          hit,
    output logic [7:0]    rd_byte
);

    logic          buf_valid;
    logic [TW-1:0] buf_tag;
    logic [15:0]   buf_word;

    // A load always wins over a clear: the caller folds any pending flush
    // into load_valid so the delivered word is simply not marked usable.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_word  <= '0;
        end else if (load) begin
            buf_valid <= load_valid;
            buf_tag   <= load_tag;
            buf_word  <= load_word;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end
    end

    assign hit     = buf_valid && (buf_tag == lookup_tag);
    assign rd_byte = sel_byte(buf_word, lookup_a0);

endmodule

// File: rtl/cart_rom_fetch.sv
// ----------------------------------------------------------------------------
// cart_rom_fetch
// Returns cartridge read data to the CPU. ROM bytes come from SDRAM through a
// one-word hit buffer; battery-SRAM reads are passed straight through.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   cs, rd     : slot select and CPU read strobe (access = cs && rd)
//   mem_addr   : translated ROM byte address from the mapper
//   sram_oe    : access targets battery SRAM
//   sram_q     : SRAM read data
//   flush      : invalidate the hit buffer
//   ram_addr   : SDRAM word address
//   ram_rd     : SDRAM read request (level)
//   ram_ready  : SDRAM data valid pulse
//   ram_dout   : SDRAM read word
//   d_to_cpu   : read data to CPU
//   cpu_wait   : holds the CPU while a fetch is outstanding
// ----------------------------------------------------------------------------
module cart_rom_fetch #(
    parameter int TIMEOUT = 64,
    parameter int AW      = 25
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          rd,
    input  logic [AW-1:0] mem_addr,
    input  logic          sram_oe,
    input  logic [7:0]    sram_q,
    input  logic          flush,
    output logic [AW-2:0] ram_addr,
    output logic          ram_rd,
    input  logic          ram_ready,
    input  logic [15:0]   ram_dout,
    output logic [7:0]    d_to_cpu,
    output logic          cpu_wait
);

    import cart_pkg::*;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [0:0]    state;
    logic          acc;
    logic          acc_d;
    logic          start;
    logic [AW-1:0] req_addr;
    logic [CW-1:0] cnt;
    logic          flush_seen;
    logic          sram_sel;
    logic          buf_hit;
    logic [7:0]    buf_byte;
    logic          hit_now;
    logic          fill_done;
    logic          timeout_done;

    // Accesses are edge-triggered so a CPU holding rd does not refetch.
    assign acc   = cs && rd;
    assign start = acc && !acc_d;

    // A flush arriving with the start must not be served from stale data.
    assign hit_now = buf_hit && !flush;

    assign fill_done    = (state == REQ) && ram_rd && ram_ready;
    assign timeout_done = (state == REQ) && !fill_done && (cnt == CNT_LAST);

    // Hold the latched address during a fetch so SDRAM sees a stable request.
    assign ram_addr = (state == REQ) ? req_addr[AW-1:1] : mem_addr[AW-1:1];

    // A flush seen at any point during the fetch keeps the returned word out
    // of the buffer; abandoned fetches also drop whatever was buffered.
    cart_word_buf #(
        .TW(AW - 1)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (fill_done),
        .load_valid (!flush_seen && !flush),
        .load_tag   (req_addr[AW-1:1]),
        .load_word  (ram_dout),
        .clear      (flush || timeout_done),
        .lookup_tag (mem_addr[AW-1:1]),
        .lookup_a0  (mem_addr[0]),
        .hit        (buf_hit),
        .rd_byte    (buf_byte)
    );

    // Fetch FSM: IDLE serves SRAM reads and buffer hits directly and launches
    // an SDRAM request on a miss; REQ waits for ram_ready or the timeout.
    // Starts seen while in REQ are ignored since the CPU is being held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc_d      <= 1'b0;
            ram_rd     <= 1'b0;
            cpu_wait   <= 1'b0;
            d_to_cpu   <= FILL_BYTE;
            cnt        <= '0;
            req_addr   <= '0;
            flush_seen <= 1'b0;
            sram_sel   <= 1'b0;
        end else begin
            acc_d <= acc;
            if (!acc) begin
                sram_sel <= 1'b0;
            end
            case (state)
                IDLE: begin
                    flush_seen <= 1'b0;
                    if (start) begin
                        if (sram_oe) begin
                            sram_sel <= 1'b1;
                            d_to_cpu <= sram_q;
                        end else if (hit_now) begin
                            sram_sel <= 1'b0;
                            d_to_cpu <= buf_byte;
                        end else begin
                            sram_sel <= 1'b0;
                            req_addr <= mem_addr;
                            ram_rd   <= 1'b1;
                            cpu_wait <= 1'b1;
                            cnt      <= '0;
                            state    <= REQ;
                        end
                    end else if (sram_sel && acc) begin
                        d_to_cpu <= sram_q;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_seen <= 1'b1;
                    end
                    if (fill_done) begin
                        d_to_cpu <= sel_byte(ram_dout, req_addr[0]);
                        ram_rd   <= 1'b0;
                        cpu_wait <= 1'b0;
                        state    <= IDLE;
                    end else if (timeout_done) begin
                        d_to_cpu <= FILL_BYTE;
                        ram_rd   <= 1'b0;
                        cpu_wait <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// ----------------------------------------------------------------------------
// tb_cart_rom_fetch
// Directed self-checking bench for cart_rom_fetch.
// ----------------------------------------------------------------------------
module tb_cart_rom_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic [24:0] mem_addr = '0;
    logic        sram_oe = 1'b0;
    logic [7:0]  sram_q = '0;
    logic        flush = 1'b0;
    logic [23:0] ram_addr;
    logic        ram_rd;
    logic        ram_ready = 1'b0;
    logic [15:0] ram_dout = '0;
    logic [7:0]  d_to_cpu;
    logic        cpu_wait;

    int pass_cnt = 0;
    int check_cnt = 0;

    cart_rom_fetch #(
        .TIMEOUT(64),
        .AW(25)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rd        (rd),
        .mem_addr  (mem_addr),
        .sram_oe   (sram_oe),
        .sram_q    (sram_q),
        .flush     (flush),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_ready (ram_ready),
        .ram_dout  (ram_dout),
        .d_to_cpu  (d_to_cpu),
        .cpu_wait  (cpu_wait)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task tick;
        @(posedge clk);
        #1;
    endtask

    task start_read(input logic [24:0] a, input logic oe);
        mem_addr = a;
        sram_oe  = oe;
        cs       = 1'b1;
        rd       = 1'b1;
        tick();
    endtask

    task end_read;
        cs      = 1'b0;
        rd      = 1'b0;
        sram_oe = 1'b0;
        tick();
    endtask

    task give_ready(input logic [15:0] w);
        ram_dout  = w;
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
    endtask

    task test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_cnt++;
        if (ram_rd !== 1'b0) $display("[TB] FAIL reset_ram_rd: got %b expected 0", ram_rd);
        else pass_cnt++;
        check_cnt++;
        if (cpu_wait !== 1'b0) $display("[TB] FAIL reset_cpu_wait: got %b expected 0", cpu_wait);
        else pass_cnt++;
        check_cnt++;
        if (d_to_cpu !== 8'hFF) $display("[TB] FAIL reset_data: got %h expected ff", d_to_cpu);
        else pass_cnt++;
    endtask

    task test_miss_then_hit;
        int waits;
        start_read(25'h0004, 1'b0);
        check_cnt++;
        if (cpu_wait !== 1'b1 || ram_rd !== 1'b1)
            $display("[TB] FAIL miss_start: got wait=%b rd=%b expected 1/1", cpu_wait, ram_rd);
        else pass_cnt++;
        check_cnt++;
        if (ram_addr !== 24'h000002) $display("[TB] FAIL miss_ram_addr: got %h expected 000002", ram_addr);
        else pass_cnt++;
        waits = 1;
        mem_addr = 25'h001FFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_wait === 1'b1) waits++;
        end
        check_cnt++;
        if (ram_addr !== 24'h000002) $display("[TB] FAIL ram_addr_stable: got %h expected 000002", ram_addr);
        else pass_cnt++;
        give_ready(16'hBBAA);
        check_cnt++;
        if (waits != 5) $display("[TB] FAIL miss_wait_cycles: got %0d expected 5", waits);
        else pass_cnt++;
        check_cnt++;
        if (d_to_cpu !== 8'hAA) $display("[TB] FAIL miss_data: got %h expected aa", d_to_cpu);
        else pass_cnt++;
        check_cnt++;
        if (cpu_wait !== 1'b0 || ram_rd !== 1'b0)
            $display("[TB] FAIL miss_release: got wait=%b rd=%b expected 0/0", cpu_wait, ram_rd);
        else pass_cnt++;
        end_read();
        start_read(25'h0005, 1'b0);
        check_cnt++;
        if (d_to_cpu !== 8'hBB) $display("[TB] FAIL hit_data: got %h expected bb", d_to_cpu);
        else pass_cnt++;
        check_cnt++;
        if (cpu_wait !== 1'b0 || ram_rd !== 1'b0)
            $display("[TB] FAIL hit_no_fetch: got wait=%b rd=%b expected 0/0", cpu_wait, ram_rd);
        else pass_cnt++;
        end_read();
    endtask

    task test_sram;
        sram_q = 8'h5C;
        start_read(25'h0123, 1'b1);
        check_cnt++;
        if (d_to_cpu !== 8'h5C) $display("[TB] FAIL sram_data: got %h expected 5c", d_to_cpu);
        else pass_cnt++;
        check_cnt++;
        if (cpu_wait !== 1'b0 || ram_rd !== 1'b0)
            $display("[TB] FAIL sram_no_fetch: got wait=%b rd=%b expected 0/0", cpu_wait, ram_rd);
        else pass_cnt++;
        sram_q = 8'hA7;
        tick();
        check_cnt++;
        if (d_to_cpu !== 8'hA7) $display("[TB] FAIL sram_follow: got %h expected a7", d_to_cpu);
        else pass_cnt++;
        end_read();
    endtask

    task test_timeout;
        int waits;
        int guard;
        start_read(25'h0100, 1'b0);
        waits = 0;
        guard = 0;
        while (cpu_wait === 1'b1 && guard < 200) begin
            waits++;
            guard++;
            tick();
        end
        check_cnt++;
        if (waits != 64) $display("[TB] FAIL timeout_cycles: got %0d expected 64", waits);
        else pass_cnt++;
        check_cnt++;
        if (d_to_cpu !== 8'hFF || ram_rd !== 1'b0)
            $display("[TB] FAIL timeout_data: got d=%h rd=%b expected ff/0", d_to_cpu, ram_rd);
        else pass_cnt++;
        end_read();
        start_read(25'h0100, 1'b0);
        check_cnt++;
        if (cpu_wait !== 1'b1) $display("[TB] FAIL timeout_rearm_miss: got %b expected 1", cpu_wait);
        else pass_cnt++;
        give_ready(16'hCAFE);
        check_cnt++;
        if (d_to_cpu !== 8'hFE) $display("[TB] FAIL rearm_data: got %h expected fe", d_to_cpu);
        else pass_cnt++;
        end_read();
    endtask

    task test_ready_in_idle;
        ram_dout  = 16'h9999;
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        check_cnt++;
        if (d_to_cpu !== 8'hFE) $display("[TB] FAIL idle_ready_ignored: got %h expected fe", d_to_cpu);
        else pass_cnt++;
        start_read(25'h0101, 1'b0);
        check_cnt++;
        if (d_to_cpu !== 8'hCA || cpu_wait !== 1'b0)
            $display("[TB] FAIL idle_ready_hit: got d=%h wait=%b expected ca/0", d_to_cpu, cpu_wait);
        else pass_cnt++;
        end_read();
    endtask

    task test_flush_during_fetch;
        start_read(25'h0200, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        give_ready(16'h1234);
        check_cnt++;
        if (d_to_cpu !== 8'h34 || cpu_wait !== 1'b0)
            $display("[TB] FAIL flush_fetch_data: got d=%h wait=%b expected 34/0", d_to_cpu, cpu_wait);
        else pass_cnt++;
        end_read();
        start_read(25'h0200, 1'b0);
        check_cnt++;
        if (cpu_wait !== 1'b1) $display("[TB] FAIL flush_reread_miss: got %b expected 1", cpu_wait);
        else pass_cnt++;
        give_ready(16'h1234);
        end_read();
        start_read(25'h0201, 1'b0);
        check_cnt++;
        if (d_to_cpu !== 8'h12 || cpu_wait !== 1'b0)
            $display("[TB] FAIL refill_hit: got d=%h wait=%b expected 12/0", d_to_cpu, cpu_wait);
        else pass_cnt++;
        end_read();
    endtask

    task test_flush_idle;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start_read(25'h0201, 1'b0);
        check_cnt++;
        if (cpu_wait !== 1'b1) $display("[TB] FAIL idle_flush_miss: got %b expected 1", cpu_wait);
        else pass_cnt++;
        give_ready(16'h1234);
        check_cnt++;
        if (d_to_cpu !== 8'h12) $display("[TB] FAIL idle_flush_data: got %h expected 12", d_to_cpu);
        else pass_cnt++;
        end_read();
        flush = 1'b1;
        start_read(25'h0200, 1'b0);
        flush = 1'b0;
        check_cnt++;
        if (cpu_wait !== 1'b1) $display("[TB] FAIL flush_start_miss: got %b expected 1", cpu_wait);
        else pass_cnt++;
        give_ready(16'h1234);
        check_cnt++;
        if (d_to_cpu !== 8'h34) $display("[TB] FAIL flush_start_data: got %h expected 34", d_to_cpu);
        else pass_cnt++;
        end_read();
    endtask

    task test_reset_mid_fetch;
        start_read(25'h0300, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_cnt++;
        if (ram_rd !== 1'b0 || cpu_wait !== 1'b0 || d_to_cpu !== 8'hFF)
            $display("[TB] FAIL reset_mid_fetch: got rd=%b wait=%b d=%h expected 0/0/ff",
                     ram_rd, cpu_wait, d_to_cpu);
        else pass_cnt++;
        reset = 1'b0;
        end_read();
        start_read(25'h0200, 1'b0);
        check_cnt++;
        if (cpu_wait !== 1'b1) $display("[TB] FAIL post_reset_miss: got %b expected 1", cpu_wait);
        else pass_cnt++;
        give_ready(16'h5678);
        end_read();
    endtask

    task test_rd_held;
        int rd_pulses;
        int wait_pulses;
        int bad_data;
        start_read(25'h0201, 1'b0);
        check_cnt++;
        if (d_to_cpu !== 8'h56 || cpu_wait !== 1'b0)
            $display("[TB] FAIL held_hit: got d=%h wait=%b expected 56/0", d_to_cpu, cpu_wait);
        else pass_cnt++;
        rd_pulses = 0;
        wait_pulses = 0;
        bad_data = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ram_rd === 1'b1) rd_pulses++;
            if (cpu_wait === 1'b1) wait_pulses++;
            if (d_to_cpu !== 8'h56) bad_data++;
        end
        check_cnt++;
        if (rd_pulses != 0 || wait_pulses != 0)
            $display("[TB] FAIL held_no_retrigger: got rd=%0d wait=%0d expected 0/0", rd_pulses, wait_pulses);
        else pass_cnt++;
        check_cnt++;
        if (bad_data != 0) $display("[TB] FAIL held_data_stable: got %0d bad cycles expected 0", bad_data);
        else pass_cnt++;
        end_read();
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_sram();
        test_timeout();
        test_ready_in_idle();
        test_flush_during_fetch();
        test_flush_idle();
        test_reset_mid_fetch();
        test_rd_held();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Safety net so a stuck simulation still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
